// File: rtl/wb_sdram_arbiter_pkg.sv
// Shared definitions for the SDRAM wishbone arbiter: wishbone cycle/burst
// type codes, the arbiter FSM state encoding and a constant log2 helper.
package wb_arb_pkg;

    // Wishbone cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // Wishbone burst type extensions
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    // Width of the slave stall counter used by the timeout build
    localparam int STALL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_ABORT = 2'b10
    } arb_state_e;

    // Ceiling log2 for sizing the round-robin pointer (minimum 1 bit for N>=2)
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            result = (int'(32'd1 << i) < value) ? (i + 1) : result;
        end
        return result;
    endfunction

endpackage

// File: rtl/wb_sdram_arbiter_picker.sv
// Round-robin priority picker: returns the first asserted request at or
// after the pointer position, wrapping around. Purely combinational.
module rr_priority_picker
    import wb_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          valid
);

    // Scan requests starting at the pointer; the first hit claims the grant
    always_comb begin
        logic [PW-1:0] idx_s;
        logic          hit_s;
        winner = '0;
        valid  = 1'b0;
        idx_s  = '0;
        hit_s  = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx_s         = PW'((int'(ptr) + i) % N);
            hit_s         = ~valid & req[idx_s];
            winner[idx_s] = winner[idx_s] | hit_s;
            valid         = valid | hit_s;
        end
    end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Wishbone N-master to 1-slave arbiter sharing the SDRAM controller port.
// Round-robin grant held for a whole bus cycle (cyc high), bursts included.
// Optional macro WB_ARB_TIMEOUT_EN adds a slave stall watchdog that errors
// the owner and parks the bus in ABORT until the owner drops cyc.
module wb_sdram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_MASTERS-1:0]        m_cyc_i,
    input  logic [NUM_MASTERS-1:0]        m_stb_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0]   m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]      m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]      m_bte_i,
    output logic [DW-1:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    output logic [NUM_MASTERS-1:0]        m_rty_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic                          s_we_o,
    output logic [AW-1:0]                 s_adr_o,
    output logic [DW-1:0]                 s_dat_o,
    output logic [DW/8-1:0]               s_sel_o,
    output logic [2:0]                    s_cti_o,
    output logic [1:0]                    s_bte_o,
    input  logic [DW-1:0]                 s_dat_i,
    input  logic                          s_ack_i,
    input  logic                          s_err_i,
    input  logic                          s_rty_i,
    output logic [NUM_MASTERS-1:0]        grant_o
);

    localparam int N  = NUM_MASTERS;
    localparam int PW = clog2(NUM_MASTERS);
    localparam int SW = DW / 8;

    arb_state_e     state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  owner_q, owner_d;

    logic [N-1:0]   pick_s;
    logic           pick_valid_s;
    logic [PW-1:0]  pick_idx_s;
    logic           own_cyc_s;
    logic           own_stb_s;
    logic           resp_s;
    logic           timeout_hit_s;

    rr_priority_picker #(
        .N  (N),
        .PW (PW)
    ) u_picker (
        .req    (m_cyc_i),
        .ptr    (ptr_q),
        .winner (pick_s),
        .valid  (pick_valid_s)
    );

    assign own_cyc_s = m_cyc_i[owner_q];
    assign own_stb_s = own_cyc_s & m_stb_i[owner_q];
    assign resp_s    = s_ack_i | s_err_i | s_rty_i;
    assign grant_o   = grant_q;

    // Convert the picker's one-hot winner into a master index
    always_comb begin
        pick_idx_s = '0;
        for (int i = 0; i < N; i++) begin
            pick_idx_s = pick_idx_s | (pick_s[i] ? PW'(i) : {PW{1'b0}});
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES - 1);

    logic [STALL_W-1:0] stall_q, stall_d;

    assign timeout_hit_s = (state_q == ST_BUSY) & own_stb_s & ~resp_s & (stall_q == STALL_LIMIT);

    // Stall counter: counts strobed cycles without any slave response
    always_comb begin
        if (state_q != ST_BUSY) begin
            stall_d = '0;
        end else if (resp_s || timeout_hit_s) begin
            stall_d = '0;
        end else if (own_stb_s) begin
            stall_d = stall_q + {{(STALL_W-1){1'b0}}, 1'b1};
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // State register: FSM state, grant, round-robin pointer and owner index
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    // Next-state: arbitrate in IDLE, hold the owner until its cyc drops
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d = ST_BUSY;
                    grant_d = pick_s;
                    owner_d = pick_idx_s;
                    ptr_d   = (pick_idx_s == PW'(N - 1)) ? {PW{1'b0}} : (pick_idx_s + {{(PW-1){1'b0}}, 1'b1});
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!own_cyc_s) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (timeout_hit_s) begin
                    state_d = ST_ABORT;
                end
`endif
                else begin
                    state_d = ST_BUSY;
                end
            end
            ST_ABORT: begin
`ifdef WB_ARB_TIMEOUT_EN
                if (!own_cyc_s) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else begin
                    state_d = ST_ABORT;
                end
`else
                // Unreachable without the watchdog; recover to a clean idle bus
                state_d = ST_IDLE;
                grant_d = '0;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Outputs: owner's request muxed to the slave, responses to the owner only
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = 3'b000;
        s_bte_o = 2'b00;
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        case (state_q)
            ST_BUSY: begin
                s_cyc_o          = own_cyc_s;
                s_stb_o          = own_stb_s;
                s_we_o           = own_cyc_s & m_we_i[owner_q];
                s_adr_o          = m_adr_i[int'(owner_q)*AW +: AW] & {AW{own_cyc_s}};
                s_dat_o          = m_dat_i[int'(owner_q)*DW +: DW] & {DW{own_cyc_s}};
                s_sel_o          = m_sel_i[int'(owner_q)*SW +: SW] & {SW{own_cyc_s}};
                s_cti_o          = m_cti_i[int'(owner_q)*3 +: 3] & {3{own_cyc_s}};
                s_bte_o          = m_bte_i[int'(owner_q)*2 +: 2] & {2{own_cyc_s}};
                m_dat_o          = s_dat_i;
                m_ack_o[owner_q] = s_ack_i;
                m_err_o[owner_q] = s_err_i | timeout_hit_s;
                m_rty_o[owner_q] = s_rty_i;
            end
            ST_ABORT: begin
                // Slave is cut off; late responses are swallowed
                s_cyc_o = 1'b0;
            end
            default: begin
                s_cyc_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Self-checking bench for wb_sdram_arbiter: directed scenarios with literal
// expectations plus randomized masters/slave checked every cycle against a
// behavioural arbiter model (owner / rr pointer / stall count).
`timescale 1ns/1ps
module tb_wb_sdram_arbiter;
    import wb_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic clock = 1'b0;
    logic reset_n;
    logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
    logic [N*AW-1:0] m_adr_i;
    logic [N*DW-1:0] m_dat_i;
    logic [N*SW-1:0] m_sel_i;
    logic [N*3-1:0]  m_cti_i;
    logic [N*2-1:0]  m_bte_i;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, m_rty_o, grant_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [2:0]      s_cti_o;
    logic [1:0]      s_bte_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_err_i, s_rty_i;

    wb_sdram_arbiter #(
        .NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int fails   = 0;

    // Behavioural model: phase 0=idle 1=owned 2=aborted, owner -1 when free
    int md_phase = 0;
    int md_owner = -1;
    int md_ptr   = 0;
    int md_stall = 0;

    // Per-master traffic generator state
    int       beats [N];
    bit       burst [N];
    bit [N-1:0] done_ok, done_bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare DUT outputs with the model, then advance the model across the edge
    task automatic check_and_model();
        logic e_cyc, e_stb, e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat, e_mdat;
        logic [SW-1:0] e_sel;
        logic [2:0]    e_cti;
        logic [1:0]    e_bte;
        logic [N-1:0]  e_ack, e_err, e_rty, e_gnt;
        bit resp, to_hit, found;
        int o, w;
        e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_dat = '0; e_sel = '0;
        e_cti = '0; e_bte = '0; e_mdat = '0; e_ack = '0; e_err = '0; e_rty = '0; e_gnt = '0;
        o = md_owner;
        if (md_phase == 1) begin
            if (m_cyc_i[o]) begin
                e_cyc = 1'b1;
                e_stb = m_stb_i[o];
                e_we  = m_we_i[o];
                e_adr = m_adr_i[o*AW +: AW];
                e_dat = m_dat_i[o*DW +: DW];
                e_sel = m_sel_i[o*SW +: SW];
                e_cti = m_cti_i[o*3 +: 3];
                e_bte = m_bte_i[o*2 +: 2];
            end
            e_mdat   = s_dat_i;
            e_ack[o] = s_ack_i;
            e_err[o] = s_err_i;
            e_rty[o] = s_rty_i;
        end
        resp   = s_ack_i | s_err_i | s_rty_i;
        to_hit = 0;
`ifdef WB_ARB_TIMEOUT_EN
        to_hit = (md_phase == 1) && e_stb && !resp && (md_stall == TO - 1);
        if (to_hit) e_err[o] = 1'b1;
`endif
        if (md_owner >= 0) e_gnt[md_owner] = 1'b1;

        chk("s_cyc", s_cyc_o, e_cyc);
        chk("s_stb", s_stb_o, e_stb);
        chk("s_we",  s_we_o,  e_we);
        chk("s_adr", s_adr_o, e_adr);
        chk("s_dat", s_dat_o, e_dat);
        chk("s_sel", s_sel_o, e_sel);
        chk("s_cti", s_cti_o, e_cti);
        chk("s_bte", s_bte_o, e_bte);
        chk("m_dat", m_dat_o, e_mdat);
        chk("m_ack", m_ack_o, e_ack);
        chk("m_err", m_err_o, e_err);
        chk("m_rty", m_rty_o, e_rty);
        chk("grant", grant_o, e_gnt);

        for (int k = 0; k < N; k++) begin
            done_ok[k]  = e_ack[k] & m_stb_i[k] & m_cyc_i[k];
            done_bad[k] = (e_err[k] | e_rty[k]) & m_stb_i[k] & m_cyc_i[k];
        end

        if (!reset_n) begin
            md_phase = 0; md_owner = -1; md_ptr = 0; md_stall = 0;
        end else if (md_phase == 0) begin
            found = 0;
            for (int i = 0; i < N; i++) begin
                w = (md_ptr + i) % N;
                if (!found && m_cyc_i[w]) begin
                    found = 1; md_owner = w; md_ptr = (w + 1) % N; md_phase = 1; md_stall = 0;
                end
            end
        end else if (md_phase == 1) begin
            if (!m_cyc_i[md_owner]) begin
                md_phase = 0; md_owner = -1;
            end else if (to_hit) begin
                md_phase = 2; md_stall = 0;
            end else if (resp) begin
                md_stall = 0;
            end else if (e_stb) begin
                md_stall++;
            end
        end else begin
            if (!m_cyc_i[md_owner]) begin
                md_phase = 0; md_owner = -1;
            end
        end
    endtask

    // One cycle: compare on the falling edge, return just after the rising edge
    task automatic tick();
        @(negedge clock);
        check_and_model();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_adr_i = '0; m_dat_i = '0;
        m_sel_i = '0; m_cti_i = '0; m_bte_i = '0;
        s_dat_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        tick();
        reset_n = 1;
    endtask

    task automatic new_beat(input int k, input logic [AW-1:0] a);
        m_adr_i[k*AW +: AW] = a;
        m_dat_i[k*DW +: DW] = $urandom;
        m_sel_i[k*SW +: SW] = SW'($urandom);
        m_cti_i[k*3 +: 3]   = (beats[k] == 1) ? (burst[k] ? CTI_END : CTI_CLASSIC) : CTI_INCR;
        m_bte_i[k*2 +: 2]   = BTE_LINEAR;
    endtask

    task automatic drop(input int k);
        m_cyc_i[k] = 0;
        m_stb_i[k] = 0;
    endtask

    // Random wishbone masters that honour ack/err/rty and sometimes abandon
    task automatic drive_random();
        for (int k = 0; k < N; k++) begin
            if (m_cyc_i[k]) begin
                if (done_bad[k] || (done_ok[k] && beats[k] <= 1)) begin
                    drop(k);
                end else if (done_ok[k]) begin
                    beats[k]--;
                    new_beat(k, m_adr_i[k*AW +: AW] + 32'd4);
                    m_stb_i[k] = ($urandom_range(3) != 0);
                end else if ($urandom_range(63) == 0) begin
                    drop(k);
                end else begin
                    m_stb_i[k] = 1'b1;
                end
            end else if ($urandom_range(3) == 0) begin
                beats[k]   = $urandom_range(1, 8);
                burst[k]   = (beats[k] > 1);
                m_cyc_i[k] = 1'b1;
                m_stb_i[k] = 1'b1;
                m_we_i[k]  = 1'($urandom);
                new_beat(k, $urandom & 32'hFFFF_FFFC);
            end
        end
        s_dat_i = $urandom;
        s_ack_i = 1'($urandom);
        s_err_i = ($urandom_range(31) == 0);
        s_rty_i = ($urandom_range(31) == 0);
        reset_n = ($urandom_range(199) != 0);
    endtask

    logic [N-1:0] exp2 [10] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010,
                                3'b010, 3'b000, 3'b100, 3'b100, 3'b000};

    initial begin
        logic [N-1:0] g, acked;
        int errw, errcnt;
        idle_inputs();
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1;

        // Single master write reaches the slave one cycle after cyc
        m_cyc_i[0] = 1; m_stb_i[0] = 1; m_we_i[0] = 1;
        m_adr_i[0 +: AW] = 32'h0000_0100; m_dat_i[0 +: DW] = 32'hDEAD_BEEF;
        m_sel_i[0 +: SW] = 4'b1111;
        #1;
        chk("t1_idle_scyc", s_cyc_o, 1'b0);
        chk("t1_idle_grant", grant_o, 3'b000);
        tick();
        chk("t1_grant", grant_o, 3'b001);
        chk("t1_scyc", s_cyc_o, 1'b1);
        chk("t1_adr", s_adr_o, 32'h0000_0100);
        chk("t1_dat", s_dat_o, 32'hDEAD_BEEF);
        s_ack_i = 1;
        #1;
        chk("t1_ack", m_ack_o, 3'b001);
        tick();
        drop(0); s_ack_i = 0;
        tick();
        chk("t1_release", grant_o, 3'b000);

        // Three simultaneous requests after reset: 0, 1, 2 with a dead cycle between
        do_reset();
        m_cyc_i = 3'b111; m_stb_i = 3'b111; acked = '0;
        for (int w = 0; w < 10; w++) begin
            chk($sformatf("t2_grant_w%0d", w), grant_o, exp2[w]);
            g = grant_o;
            s_ack_i = 0;
            for (int k = 0; k < N; k++) begin
                if (g[k] && !acked[k]) begin
                    s_ack_i = 1; acked[k] = 1;
                end else if (g[k]) begin
                    drop(k);
                end
            end
            tick();
        end

        // Master 0 re-requests immediately; waiting master 2 goes first
        do_reset();
        m_cyc_i = 3'b101; m_stb_i = 3'b101;
        tick();
        s_ack_i = 1;
        tick();
        s_ack_i = 0; drop(0);
        tick();
        m_cyc_i[0] = 1; m_stb_i[0] = 1;
        tick();
        chk("t4_no_starve", grant_o, 3'b100);
        idle_inputs();
        tick();
        tick();

        // Hung slave
        do_reset();
        m_cyc_i[1] = 1; m_stb_i[1] = 1;
        errw = -1; errcnt = 0;
        for (int w = 0; w < 40; w++) begin
            if (m_err_o[1]) begin
                errcnt++;
                if (errw < 0) errw = w;
            end
            tick();
        end
`ifdef WB_ARB_TIMEOUT_EN
        chk("t6_err_cycle", errw, 16);
        chk("t6_err_count", errcnt, 1);
        chk("t6_abort_scyc", s_cyc_o, 1'b0);
        chk("t6_abort_grant", grant_o, 3'b010);
`else
        chk("t6_no_err", errcnt, 0);
        chk("t6_held_scyc", s_cyc_o, 1'b1);
        chk("t6_held_grant", grant_o, 3'b010);
`endif
        drop(1);
        tick();
        chk("t6_freed", grant_o, 3'b000);

        // Randomized traffic with occasional resets
        do_reset();
        for (int k = 0; k < N; k++) begin
            beats[k] = 0; burst[k] = 0;
        end
        done_ok = '0; done_bad = '0;
        for (int c = 0; c < 4000; c++) begin
            drive_random();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
